alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin arbitration,
// a three-state IDLE/EXEC/DONE sequence, and registered result/flags capture.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       op0,
    input  logic [3:0]       op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [4:0]       alu_flags,
    output logic             grant0,
    output logic             grant1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             illegal,
    output logic             busy
);
    localparam logic [3:0] OP_CMP = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ptr;
    logic             r_win;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;

    logic             w_start;
    logic             w_win;
    logic             w_exec;
    logic             w_done;
    logic             w_load_result;
    logic             w_load_flags;
    logic [1:0]       w_sel;

    // On a tie the requester that did not win last time is chosen.
    assign w_start = req0 | req1;
    assign w_win   = (req0 & req1) ? ~r_ptr : req1;

    assign w_load_result = ~r_op[3] & (r_op != OP_CMP);
    assign w_load_flags  = ~r_op[3] & (r_op <= OP_CMP);

    always_comb begin
        w_state_next = r_state;
        w_exec       = 1'b0;
        w_done       = 1'b0;
        busy         = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_ctrl     = OP_NOP;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec       = 1'b1;
                busy         = 1'b1;
                alu_a        = r_a;
                alu_b        = r_b;
                alu_ctrl     = r_op;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                busy         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            assign w_sel[gi] = (r_win == 1'(gi));
        end
    endgenerate

    assign grant0  = w_exec & w_sel[0];
    assign grant1  = w_exec & w_sel[1];
    assign done0   = w_done & w_sel[0];
    assign done1   = w_done & w_sel[1];
    assign illegal = w_done & r_op[3];
    assign result  = r_result;
    assign flags   = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 1'b1;
            r_win    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_start) begin
                r_win <= w_win;
                r_ptr <= w_win;
                r_a   <= w_win ? a1 : a0;
                r_b   <= w_win ? b1 : b0;
                r_op  <= w_win ? op1 : op0;
            end
            // Capture happens at the edge closing EXEC, while the ALU sees the latched operands.
            if (r_state == ST_EXEC) begin
                if (w_load_result) begin
                    r_result <= alu_result;
                end
                if (w_load_flags) begin
                    r_flags <= alu_flags;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter with a behavioural ALU stub
// and a transaction-level reference model of arbitration and result/flag capture.
module tb_alu_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [3:0]   op0, op1;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_ctrl;
    logic [4:0]   alu_flags;
    logic         grant0, grant1, done0, done1, illegal, busy;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int           checks = 0;
    int           errors = 0;
    int           ntxn = 0;
    int           last_win = -1;
    logic         ptr_m;
    logic [W-1:0] res_m;
    logic [4:0]   flg_m;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
        .result(result), .flags(flags), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stub; flags are {C,L,F,Z,N}. Non-arithmetic ops emit nonzero junk flags.
    function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  f;
        s = '0;
        r = '0;
        f = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; f = {s[16], 1'b0, s[16], r == 16'd0, r[15]}; end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; f = {s[16], 1'b0, s[16], r == 16'd0, r[15]}; end
            4'd2: begin r = a - b; f = {1'b0, a < b, 1'b0, a == b, $signed(a) < $signed(b)}; end
            4'd3: begin r = a & b; f = 5'b01010; end
            4'd4: begin r = a | b; f = 5'b01010; end
            4'd5: begin r = a ^ b; f = 5'b01010; end
            4'd6, 4'd7: begin r = b; f = 5'b01010; end
            4'd8: begin r = '0; f = '0; end
            default: begin r = a ^ 16'hDEAD; f = 5'b11111; end
        endcase
        return {f, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rand_op();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(8, 15));
        return 4'($urandom_range(0, 7));
    endfunction

    task automatic raise(input int r);
        if (r == 0) begin
            op0 = rand_op(); a0 = 16'($urandom); b0 = 16'($urandom); req0 = 1'b1;
        end else begin
            op1 = rand_op(); a1 = 16'($urandom); b1 = 16'($urandom); req1 = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ptr_m = 1'b1;
        res_m = '0;
        flg_m = '0;
    endtask

    // One full IDLE->EXEC->DONE->IDLE transaction, called in an IDLE cycle with a request pending.
    task automatic do_txn(input bit scramble, input bit cont);
        int           w;
        logic [3:0]   wop;
        logic [15:0]  wa, wb;
        logic [20:0]  r;
        chk("txn_req_pending", 32'(req0 | req1), 32'd1);
        if (!(req0 | req1)) return;
        w = (req0 && req1) ? (ptr_m ? 0 : 1) : (req1 ? 1 : 0);
        if (w == 0) begin wop = op0; wa = a0; wb = b0; end
        else begin wop = op1; wa = a1; wb = b1; end

        @(posedge clk); #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_grant0", 32'(grant0), 32'(w == 0));
        chk("exec_grant1", 32'(grant1), 32'(w == 1));
        chk("exec_done", 32'({done1, done0}), 32'd0);
        chk("exec_illegal", 32'(illegal), 32'd0);
        chk("exec_alu_a", 32'(alu_a), 32'(wa));
        chk("exec_alu_b", 32'(alu_b), 32'(wb));
        chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(wop));
        ptr_m = (w == 1);
        r = alu_fn(wop, wa, wb);
        if (!wop[3]) begin
            if (wop != 4'd2) res_m = r[15:0];
            if (wop <= 4'd2) flg_m = r[20:16];
        end
        if (scramble) begin
            if (w == 0) begin a0 = ~a0; b0 = b0 + 16'd17; op0 = op0 ^ 4'b0101; end
            else begin a1 = ~a1; b1 = b1 + 16'd17; op1 = op1 ^ 4'b0101; end
        end
        if (cont && $urandom_range(0, 3) == 0) begin
            if (w == 0 && !req1) raise(1);
            if (w == 1 && !req0) raise(0);
        end

        @(posedge clk); #1;
        chk("done_winner", 32'(w == 0 ? done0 : done1), 32'd1);
        chk("done_loser", 32'(w == 0 ? done1 : done0), 32'd0);
        chk("done_grants", 32'({grant1, grant0}), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_illegal", 32'(illegal), 32'(wop[3]));
        chk("done_result", 32'(result), 32'(res_m));
        chk("done_flags", 32'(flags), 32'(flg_m));
        chk("done_alu_ctrl", 32'(alu_ctrl), 32'h8);
        chk("done_alu_a", 32'(alu_a), 32'd0);
        ntxn++;
        $display("txn %0d req%0d op=%b a=%h b=%h result=%h flags=%b illegal=%b",
                 ntxn, w, wop, wa, wb, result, flags, illegal);

        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'({done1, done0}), 32'd0);
        last_win = w;
        if (cont && $urandom_range(0, 1) == 1) raise(w);
        else if (w == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
        ptr_m = 1'b1; res_m = '0; flg_m = '0;

        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grants", 32'({grant1, grant0}), 32'd0);
        chk("rst_dones", 32'({done1, done0}), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h8);

        // Request present while reset is still high must be ignored at that edge.
        req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0003; op0 = 4'b0000;
        @(posedge clk); #1;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_grant", 32'(grant0), 32'd0);
        reset = 1'b0;
        do_txn(0, 0);
        chk("single_result", 32'(result), 32'h0008);
        chk("single_flags", 32'(flags), 32'd0);

        // Tie and round-robin from reset.
        do_reset();
        req0 = 1; op0 = 4'd6; a0 = 16'h1111; b0 = 16'h1234;
        req1 = 1; op1 = 4'd4; a1 = 16'h00F0; b1 = 16'h0F00;
        do_txn(0, 0);
        chk("tie1_winner", 32'(last_win), 32'd0);
        req0 = 1; op0 = 4'd0; a0 = 16'd1; b0 = 16'd2;
        do_txn(0, 0);
        chk("tie2_winner", 32'(last_win), 32'd1);
        chk("tie2_result", 32'(result), 32'h0FF0);
        req1 = 1; op1 = 4'd7; a1 = 16'h0; b1 = 16'hABCD;
        do_txn(0, 0);
        chk("tie3_winner", 32'(last_win), 32'd0);
        do_txn(0, 0);
        chk("tie4_winner", 32'(last_win), 32'd1);
        chk("tie4_result", 32'(result), 32'hABCD);

        // CMP keeps result.
        req0 = 1; op0 = 4'd0; a0 = 16'hFFFF; b0 = 16'h0001;
        do_txn(0, 0);
        chk("add_wrap_result", 32'(result), 32'h0000);
        chk("add_wrap_flags", 32'(flags), 32'b10110);
        req0 = 1; op0 = 4'd2; a0 = 16'd2; b0 = 16'd7;
        do_txn(0, 0);
        chk("cmp_result", 32'(result), 32'h0000);
        chk("cmp_flags", 32'(flags), 32'b01001);

        // Logic op keeps flags.
        req1 = 1; op1 = 4'd1; a1 = 16'd3; b1 = 16'd5;
        do_txn(0, 0);
        chk("sub_result", 32'(result), 32'hFFFE);
        chk("sub_flags", 32'(flags), 32'b10101);
        req1 = 1; op1 = 4'd5; a1 = 16'h00F0; b1 = 16'h0FF0;
        do_txn(0, 0);
        chk("xor_result", 32'(result), 32'h0F00);
        chk("xor_flags", 32'(flags), 32'b10101);

        // Illegal opcode.
        req1 = 1; op1 = 4'b1010; a1 = 16'h1234; b1 = 16'h5678;
        do_txn(0, 0);
        chk("illegal_result", 32'(result), 32'h0F00);
        chk("illegal_flags", 32'(flags), 32'b10101);

        // Inputs changing during EXEC must not reach the ALU.
        req0 = 1; op0 = 4'd3; a0 = 16'hF0F0; b0 = 16'h3C3C;
        do_txn(1, 0);
        chk("latched_result", 32'(result), 32'h3030);

        // Reset in EXEC aborts and restores the pointer.
        req0 = 1; op0 = 4'd0; a0 = 16'd1; b0 = 16'd1;
        @(posedge clk); #1;
        chk("abort_exec_grant", 32'(grant0), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dones", 32'({done1, done0}), 32'd0);
        chk("abort_grants", 32'({grant1, grant0}), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        reset = 1'b0;
        ptr_m = 1'b1; res_m = '0; flg_m = '0;
        req1 = 1; op1 = 4'd6; a1 = 16'h0; b1 = 16'h7777;
        do_txn(0, 0);
        chk("abort_tie_winner", 32'(last_win), 32'd0);
        chk("abort_rerun_result", 32'(result), 32'h0002);
        do_txn(0, 0);
        chk("abort_second_winner", 32'(last_win), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int pick;
            if (!(req0 | req1)) begin
                pick = $urandom_range(0, 3);
                if (pick == 0) begin
                    @(posedge clk); #1;
                    chk("gap_busy", 32'(busy), 32'd0);
                end
                if (pick != 2) raise(0);
                if (pick != 1) raise(1);
            end
            do_txn(1'($urandom_range(0, 1)), 1'b1);
        end
        for (int k = 0; k < 4 && (req0 | req1); k++) do_txn(0, 0);
        chk("drain_idle", 32'({req1, req0}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
